// File: rtl/wb_pkg.sv
// wb_pkg: shared types and load funct3 encodings for the writeback stage
package wb_pkg;
    typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4, WB_IMM} wb_sel_e;
    typedef enum logic [1:0] {IDLE, WAIT_RSP, COMMIT} wb_state_e;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/load_align.sv
// load_align: selects and sign/zero-extends a byte, halfword or word of a raw load
// ports: raw (loaded word), funct3 (load type), offset (addr[1:0]), value (extended result)
// Reserved funct3 encodings fall through to a full-word load.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] value
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = raw[{offset, 3'b000} +: 8];
        h = offset[1] ? raw[31:16] : raw[15:0];
        value = funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
                funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
                funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
                funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} : raw;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage selecting and committing register file writes
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_reg_wr,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [XLEN-1:0] mem_imm,
  input  logic [2:0]      mem_load_funct3,
  input  logic            lsu_rsp_valid,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            write_en,
  output logic [4:0]      write_register,
  output logic [XLEN-1:0] data_write,
  output logic            wb_pending,
  output logic [4:0]      wb_pending_rd,
  output logic            wb_timeout_err
);
  wb_state_e       state, state_nx;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic [XLEN-1:0] aligned, sel_val;
  logic            accept, is_load, rsp, tmo, done;
  load_align #(.XLEN(XLEN)) u_align (.raw(lsu_rdata), .funct3(ld_f3), .offset(ld_off), .value(aligned));
  assign mem_ready = state != WAIT_RSP;
  assign accept    = mem_valid && mem_ready;
  assign is_load   = mem_wb_sel == WB_LOAD && mem_reg_wr;
  assign rsp       = state == WAIT_RSP && lsu_rsp_valid;
  assign done      = rsp || tmo;
  assign sel_val   = mem_wb_sel == WB_PC4 ? mem_pc4 : mem_wb_sel == WB_IMM ? mem_imm : mem_alu_result;
`ifdef WB_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = state == WAIT_RSP && !lsu_rsp_valid && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      wb_timeout_err <= 1'b0;
    end else begin
      cnt            <= state == WAIT_RSP ? cnt + 16'd1 : '0;
      wb_timeout_err <= wb_timeout_err || tmo;
    end
  end
`else
  assign tmo            = 1'b0;
  assign wb_timeout_err = 1'b0;
`endif
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  always_comb state_nx = state == WAIT_RSP ? (done ? COMMIT : WAIT_RSP) : accept ? (is_load ? WAIT_RSP : COMMIT) : IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      write_en       <= 1'b0;
      write_register <= '0;
      data_write     <= '0;
      wb_pending     <= 1'b0;
      wb_pending_rd  <= '0;
      ld_f3          <= '0;
      ld_off         <= '0;
    end else begin
      write_en <= 1'b0;
      if (accept && !is_load) begin
        write_en <= mem_reg_wr && mem_rd != '0;
        if (mem_reg_wr && mem_rd != '0) begin
          write_register <= mem_rd;
          data_write     <= sel_val;
        end
      end else if (done) begin
        write_en <= wb_pending_rd != '0;
        if (wb_pending_rd != '0) begin
          write_register <= wb_pending_rd;
          data_write     <= tmo ? '0 : aligned;
        end
      end
      if (accept && is_load) begin
        wb_pending    <= 1'b1;
        wb_pending_rd <= mem_rd;
        ld_f3         <= mem_load_funct3;
        ld_off        <= mem_alu_result[1:0];
      end else if (done) begin
        wb_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage
module tb_writeback_stage;
  logic        clock = 1'b0, reset = 1'b1;
  logic        mem_valid = 1'b0, mem_ready, mem_reg_wr = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [31:0] mem_alu_result = '0, mem_pc4 = '0, mem_imm = '0;
  logic [2:0]  mem_load_funct3 = '0;
  logic        lsu_rsp_valid = 1'b0;
  logic [31:0] lsu_rdata = '0;
  logic        write_en, wb_pending, wb_timeout_err;
  logic [4:0]  write_register, wb_pending_rd;
  logic [31:0] data_write;
  int          errors = 0, checks = 0;
  always #5 clock = ~clock;
  writeback_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg_wr(mem_reg_wr), .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
    .mem_alu_result(mem_alu_result), .mem_pc4(mem_pc4), .mem_imm(mem_imm),
    .mem_load_funct3(mem_load_funct3), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .write_en(write_en), .write_register(write_register), .data_write(data_write),
    .wb_pending(wb_pending), .wb_pending_rd(wb_pending_rd), .wb_timeout_err(wb_timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val, input logic [2:0] f3);
    mem_valid = 1'b1; mem_reg_wr = 1'b1; mem_wb_sel = sel; mem_rd = rd; mem_load_funct3 = f3;
    mem_alu_result = val; mem_pc4 = val; mem_imm = val;
  endtask
  task automatic load_once(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp, input string tag);
    issue(2'd1, rd, addr, f3);
    cyc();
    mem_valid = 1'b0;
    chk({tag, "_ready_wait"}, 32'(mem_ready), 32'd0);
    lsu_rsp_valid = 1'b1; lsu_rdata = rdata;
    cyc();
    lsu_rsp_valid = 1'b0;
    chk({tag, "_we"}, 32'(write_en), 32'd1);
    chk({tag, "_data"}, data_write, exp);
  endtask
  initial begin
    @(negedge clock);
    cyc();
    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_wreg", 32'(write_register), 32'd0);
    chk("rst_data", data_write, 32'd0);
    chk("rst_pend", 32'(wb_pending), 32'd0);
    chk("rst_pend_rd", 32'(wb_pending_rd), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);
    chk("rst_tmo", 32'(wb_timeout_err), 32'd0);
    reset = 1'b0;
    cyc();
    issue(2'd0, 5'd5, 32'h1234_5678, 3'd0);
    cyc();
    mem_valid = 1'b0;
    chk("alu_we", 32'(write_en), 32'd1);
    chk("alu_wreg", 32'(write_register), 32'd5);
    chk("alu_data", data_write, 32'h1234_5678);
    cyc();
    chk("alu_we_once", 32'(write_en), 32'd0);
    chk("alu_data_hold", data_write, 32'h1234_5678);
    issue(2'd2, 5'd1, 32'h0000_0104, 3'd0);
    chk("b2b_ready0", 32'(mem_ready), 32'd1);
    cyc();
    chk("b2b_we0", 32'(write_en), 32'd1);
    chk("b2b_wreg0", 32'(write_register), 32'd1);
    chk("b2b_data0", data_write, 32'h0000_0104);
    issue(2'd3, 5'd2, 32'hABCD_E000, 3'd0);
    chk("b2b_ready1", 32'(mem_ready), 32'd1);
    cyc();
    mem_valid = 1'b0;
    chk("b2b_we1", 32'(write_en), 32'd1);
    chk("b2b_wreg1", 32'(write_register), 32'd2);
    chk("b2b_data1", data_write, 32'hABCD_E000);
    cyc();
    chk("b2b_idle_we", 32'(write_en), 32'd0);
    issue(2'd1, 5'd7, 32'h1000_0002, 3'b000);
    lsu_rsp_valid = 1'b1; lsu_rdata = 32'h0000_00FF;
    cyc();
    mem_valid = 1'b0; lsu_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lb_pend", 32'(wb_pending), 32'd1);
      chk("lb_pend_rd", 32'(wb_pending_rd), 32'd7);
      chk("lb_ready", 32'(mem_ready), 32'd0);
      chk("lb_we_wait", 32'(write_en), 32'd0);
      if (i == 2) begin lsu_rsp_valid = 1'b1; lsu_rdata = 32'h0080_0000; end
      cyc();
    end
    lsu_rsp_valid = 1'b0;
    chk("lb_we", 32'(write_en), 32'd1);
    chk("lb_wreg", 32'(write_register), 32'd7);
    chk("lb_data", data_write, 32'hFFFF_FF80);
    chk("lb_pend_clr", 32'(wb_pending), 32'd0);
    chk("lb_ready_back", 32'(mem_ready), 32'd1);
    cyc();
    load_once(5'd9, 32'h2000_0002, 3'b101, 32'h8001_0000, 32'h0000_8001, "lhu");
    load_once(5'd10, 32'h2000_0001, 3'b001, 32'h1234_8765, 32'hFFFF_8765, "lh_odd");
    load_once(5'd11, 32'h2000_0003, 3'b011, 32'hCAFE_F00D, 32'hCAFE_F00D, "rsvd_lw");
    load_once(5'd12, 32'h2000_0003, 3'b100, 32'h8100_0000, 32'h0000_0081, "lbu3");
    cyc();
    lsu_rsp_valid = 1'b1; lsu_rdata = 32'hDEAD_BEEF;
    cyc();
    lsu_rsp_valid = 1'b0;
    chk("spur_we", 32'(write_en), 32'd0);
    chk("spur_data", data_write, 32'h0000_0081);
    issue(2'd0, 5'd0, 32'hFFFF_FFFF, 3'd0);
    cyc();
    mem_valid = 1'b0;
    chk("rd0_we", 32'(write_en), 32'd0);
    chk("rd0_data", data_write, 32'h0000_0081);
    issue(2'd1, 5'd3, 32'h3000_0000, 3'b010);
    cyc();
    mem_valid = 1'b0;
    chk("rst_mid_pend", 32'(wb_pending), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_pend_clr", 32'(wb_pending), 32'd0);
    chk("rst_mid_we", 32'(write_en), 32'd0);
    lsu_rsp_valid = 1'b1; lsu_rdata = 32'h5555_5555;
    cyc();
    lsu_rsp_valid = 1'b0;
    chk("rst_mid_late_rsp_we", 32'(write_en), 32'd0);
    chk("rst_mid_ready", 32'(mem_ready), 32'd1);
`ifdef WB_TIMEOUT_EN
    begin
      int n = 0;
      issue(2'd1, 5'd4, 32'h4000_0000, 3'b010);
      cyc();
      mem_valid = 1'b0;
      while (!write_en && n < 40) begin
        n++;
        cyc();
      end
      chk("tmo_wait_cycles", 32'(n), 32'd8);
      chk("tmo_we", 32'(write_en), 32'd1);
      chk("tmo_data", data_write, 32'd0);
      chk("tmo_err", 32'(wb_timeout_err), 32'd1);
      cyc();
      cyc();
      chk("tmo_err_sticky", 32'(wb_timeout_err), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("tmo_err_rst", 32'(wb_timeout_err), 32'd0);
    end
`else
    issue(2'd1, 5'd4, 32'h4000_0000, 3'b010);
    cyc();
    mem_valid = 1'b0;
    repeat (20) cyc();
    chk("notmo_still_pend", 32'(wb_pending), 32'd1);
    chk("notmo_err", 32'(wb_timeout_err), 32'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
